// File: rtl/stage_wb_pkg.sv
// Shared definitions for the writeback stage: trap cause codes and the
// context parked while a memory access is outstanding.
package stage_wb_pkg;

  localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACC = 4'd7;

  typedef struct packed {
    logic       ld;
    logic       rd_we;
    logic [4:0] rd;
  } mem_ctx_t;

  function automatic logic [3:0] acc_cause(input logic ld);
    return ld ? CAUSE_LD_ACC : CAUSE_ST_ACC;
  endfunction

endpackage

// File: rtl/stage_wb_watchdog.sv
// Bus-access watchdog: counts wait cycles and flags the cycle in which the
// wait reaches TIMEOUT_CYCLES. A zero TIMEOUT_CYCLES never expires.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int          CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LIM_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LIM = CW'(LIM_I);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of wait cycles already elapsed, so the current
  // cycle is wait cycle cnt_q+1; expiry fires when that reaches the limit.
  assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      cnt_q <= '0;
    else if (en_i && cnt_q != LIM)
      cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: retires ALU results and wishbone loads/stores, holding the
// pipeline while a bus access is outstanding and reporting traps.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned XLEN           = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            is_ld_mem_i,
  input  logic            is_st_mem_i,
  input  logic            rd_we_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            mem_ack_i,
  input  logic            mem_err_i,
  input  logic            e_ld_addr_mis_i,
  input  logic            e_st_addr_mis_i,
  input  logic            exc_i,
  input  logic [3:0]      exc_cause_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            retire_o,
  output logic            exc_valid_o,
  output logic [3:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_tval_o,
  output logic [XLEN-1:0] exc_pc_o
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t          state_q;
  mem_ctx_t        ctx_q, ctx_cur;
  logic [XLEN-1:0] pc_q, addr_q, pc_cur, addr_cur;
  logic            is_mem, accept, mem_active, mem_fault, mem_done;
  logic            up_exc, wd_expired;
  logic [3:0]      up_cause;
  logic [XLEN-1:0] up_tval;

  always_comb begin
    up_exc   = 1'b1;
    up_cause = exc_cause_i;
    up_tval  = '0;
    if (exc_i) begin
      up_cause = exc_cause_i;
    end else if (e_ld_addr_mis_i) begin
      up_cause = CAUSE_LD_MIS;
      up_tval  = mem_addr_i;
    end else if (e_st_addr_mis_i) begin
      up_cause = CAUSE_ST_MIS;
      up_tval  = mem_addr_i;
    end else begin
      up_exc   = 1'b0;
    end
  end

  assign is_mem     = is_ld_mem_i | is_st_mem_i;
  assign accept     = (state_q == IDLE) && valid_i && is_mem && !up_exc;
  assign stall_o    = (state_q == WAIT_MEM) || accept;
  assign mem_active = accept || (state_q == WAIT_MEM);

  // In the accept cycle the bus may already answer, so resolve against the
  // live instruction; afterwards use the parked copy.
  always_comb begin
    if (state_q == IDLE) begin
      ctx_cur.ld    = is_ld_mem_i;
      ctx_cur.rd_we = rd_we_i;
      ctx_cur.rd    = rd_addr_i;
      pc_cur        = pc_i;
      addr_cur      = mem_addr_i;
    end else begin
      ctx_cur       = ctx_q;
      pc_cur        = pc_q;
      addr_cur      = addr_q;
    end
  end

  // err beats ack; the timeout only counts when the bus stayed silent.
  assign mem_fault = mem_active &&
                     (mem_err_i || ((state_q == WAIT_MEM) && !mem_ack_i && wd_expired));
  assign mem_done  = mem_active && mem_ack_i && !mem_err_i;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == IDLE),
    .en_i     (state_q == WAIT_MEM),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ctx_q       <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      retire_o    <= 1'b0;
      exc_valid_o <= 1'b0;
      exc_cause_o <= '0;
      exc_tval_o  <= '0;
      exc_pc_o    <= '0;
    end else begin
      rf_we_o     <= 1'b0;
      retire_o    <= 1'b0;
      exc_valid_o <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        if (accept) begin
          ctx_q  <= ctx_cur;
          pc_q   <= pc_i;
          addr_q <= mem_addr_i;
        end
        if (mem_fault) begin
          state_q     <= IDLE;
          exc_valid_o <= 1'b1;
          exc_cause_o <= acc_cause(ctx_cur.ld);
          exc_tval_o  <= addr_cur;
          exc_pc_o    <= pc_cur;
        end else if (mem_done) begin
          state_q  <= IDLE;
          retire_o <= 1'b1;
          rf_we_o  <= ctx_cur.ld && ctx_cur.rd_we && (ctx_cur.rd != 5'd0);
          if (ctx_cur.ld) begin
            rf_waddr_o <= ctx_cur.rd;
            rf_wdata_o <= mem_data_i;
          end
        end else if (accept) begin
          state_q <= WAIT_MEM;
        end else if ((state_q == IDLE) && valid_i) begin
          if (up_exc) begin
            exc_valid_o <= 1'b1;
            exc_cause_o <= up_cause;
            exc_tval_o  <= up_tval;
            exc_pc_o    <= pc_i;
          end else begin
            retire_o   <= 1'b1;
            rf_we_o    <= rd_we_i && (rd_addr_i != 5'd0);
            rf_waddr_o <= rd_addr_i;
            rf_wdata_o <= alu_result_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_wb.sv
// Randomized scoreboard bench for stage_wb: a driver predicts each
// instruction's outcome from the stage rules, a monitor checks every pulse.
module tb_stage_wb;

  localparam int TMO = 4;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EXC = 3, K_LDMIS = 4, K_STMIS = 5;
  localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_TMO = 3, R_FLUSH = 4, R_RST = 5;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 0, is_ld_mem_i = 0, is_st_mem_i = 0, rd_we_i = 0;
  logic [4:0]  rd_addr_i = 0;
  logic [31:0] alu_result_i = 0, mem_addr_i = 0, pc_i = 0, mem_data_i = 0;
  logic        mem_ack_i = 0, mem_err_i = 0, e_ld_addr_mis_i = 0, e_st_addr_mis_i = 0;
  logic        exc_i = 0, flush_i = 0;
  logic [3:0]  exc_cause_i = 0;
  logic        stall_o, rf_we_o, retire_o, exc_valid_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, exc_tval_o, exc_pc_o;
  logic [3:0]  exc_cause_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        ret;
    bit        exc;
    bit [3:0]  cause;
    bit [31:0] tval;
    bit [31:0] pc;
  } ev_t;

  ev_t expq[$];

  stage_wb #(.TIMEOUT_CYCLES(TMO), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
    .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .alu_result_i(alu_result_i),
    .mem_addr_i(mem_addr_i), .pc_i(pc_i), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
    .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
    .exc_i(exc_i), .exc_cause_i(exc_cause_i), .flush_i(flush_i),
    .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .retire_o(retire_o), .exc_valid_o(exc_valid_o),
    .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o), .exc_pc_o(exc_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    ev_t e;
    bit  bad;
    if (rf_we_o || retire_o || exc_valid_o) begin
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got we=%0b ret=%0b exc=%0b cause=%0d expected no pulse",
                 rf_we_o, retire_o, exc_valid_o, exc_cause_o);
      end else begin
        e = expq.pop_front();
        bad = (rf_we_o !== e.we) || (retire_o !== e.ret) || (exc_valid_o !== e.exc);
        if (e.we  && ((rf_waddr_o !== e.wa) || (rf_wdata_o !== e.wd))) bad = 1;
        if (e.exc && ((exc_cause_o !== e.cause) || (exc_tval_o !== e.tval) || (exc_pc_o !== e.pc))) bad = 1;
        if (bad) begin
          n_fail++;
          $display("FAIL wb_event: got we=%0b wa=%0d wd=%h ret=%0b exc=%0b cause=%0d tval=%h pc=%h expected we=%0b wa=%0d wd=%h ret=%0b exc=%0b cause=%0d tval=%h pc=%h",
                   rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, exc_valid_o, exc_cause_o, exc_tval_o, exc_pc_o,
                   e.we, e.wa, e.wd, e.ret, e.exc, e.cause, e.tval, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_fields();
    is_ld_mem_i = 1'($urandom); is_st_mem_i = 1'($urandom); rd_we_i = 1'($urandom);
    rd_addr_i = 5'($urandom); alu_result_i = $urandom; mem_addr_i = $urandom; pc_i = $urandom;
    exc_i = 1'($urandom); exc_cause_i = 4'($urandom);
    e_ld_addr_mis_i = 1'($urandom); e_st_addr_mis_i = 1'($urandom); mem_data_i = $urandom;
  endtask

  task automatic do_op(input int kind, input int resp, input int nwait, input logic rdwe,
                       input logic [4:0] rd, input logic [31:0] val, input logic [31:0] addr,
                       input logic [31:0] pc, input logic [3:0] ucause);
    ev_t e;
    bit  push, mem;
    int  nw;
    e = '{default: '0};
    push = 1;
    mem = (kind == K_LD) || (kind == K_ST);
    // reference outcome straight from the stage rules
    case (kind)
      K_ALU:   begin e.ret = 1; e.we = rdwe && (rd != 0); e.wa = rd; e.wd = val; end
      K_EXC:   begin e.exc = 1; e.cause = ucause; e.tval = 0; e.pc = pc; end
      K_LDMIS: begin e.exc = 1; e.cause = 4; e.tval = addr; e.pc = pc; end
      K_STMIS: begin e.exc = 1; e.cause = 6; e.tval = addr; e.pc = pc; end
      default: begin
        if (resp == R_ACK) begin
          e.ret = 1;
          e.we  = (kind == K_LD) && rdwe && (rd != 0);
          e.wa  = rd; e.wd = val;
        end else if (resp == R_FLUSH || resp == R_RST) begin
          push = 0;
        end else begin
          e.exc = 1; e.cause = (kind == K_LD) ? 4'd5 : 4'd7; e.tval = addr; e.pc = pc;
        end
      end
    endcase
    if (push) expq.push_back(e);

    valid_i = 1;
    is_ld_mem_i = (kind == K_LD) || (kind == K_LDMIS) || ((kind == K_EXC) && 1'($urandom));
    is_st_mem_i = (kind == K_ST) || (kind == K_STMIS);
    rd_we_i = rdwe; rd_addr_i = rd; mem_addr_i = addr; pc_i = pc;
    alu_result_i = (kind == K_ALU) ? val : $urandom;
    exc_i = (kind == K_EXC); exc_cause_i = ucause;
    e_ld_addr_mis_i = (kind == K_LDMIS) || ((kind == K_EXC) && 1'($urandom));
    e_st_addr_mis_i = (kind == K_STMIS) || (((kind == K_EXC) || (kind == K_LDMIS)) && 1'($urandom));
    mem_data_i = $urandom;
    nw = (resp == R_TMO) ? TMO : nwait;
    if (mem && nw == 0) begin
      mem_ack_i = (resp == R_ACK) || (resp == R_BOTH);
      mem_err_i = (resp == R_ERR) || (resp == R_BOTH);
      if (kind == K_LD) mem_data_i = val;
    end
    @(negedge clk) chk("stall_accept", stall_o, mem);
    step();
    mem_ack_i = 0; mem_err_i = 0;

    if (mem && nw > 0) begin
      for (int w = 1; w <= nw; w++) begin
        junk_fields();
        valid_i = 1'($urandom);
        if (w == nw) begin
          case (resp)
            R_ACK:   begin mem_ack_i = 1; mem_data_i = val; end
            R_ERR:   mem_err_i = 1;
            R_BOTH:  begin mem_ack_i = 1; mem_err_i = 1; mem_data_i = val; end
            R_FLUSH: begin flush_i = 1; mem_ack_i = 1'($urandom); mem_err_i = ~mem_ack_i; end
            R_RST:   begin rst_i = 1; mem_ack_i = 1'($urandom); mem_err_i = ~mem_ack_i; end
            default: ;
          endcase
        end
        @(negedge clk) chk("stall_wait", stall_o, 1);
        step();
        mem_ack_i = 0; mem_err_i = 0; flush_i = 0; rst_i = 0;
      end
      if (resp == R_FLUSH || resp == R_RST) begin
        // a late ack after the abort must be ignored
        valid_i = 0; mem_ack_i = 1; mem_err_i = 1'($urandom); mem_data_i = $urandom;
        @(negedge clk) chk("stall_after_abort", stall_o, 0);
        if (resp == R_RST) begin
          chk("rst_mid_waddr", rf_waddr_o, 0);
          chk("rst_mid_wdata", rf_wdata_o, 0);
          chk("rst_mid_cause", exc_cause_o, 0);
          chk("rst_mid_tval",  exc_tval_o, 0);
        end
        step();
        mem_ack_i = 0; mem_err_i = 0;
      end
    end
    valid_i = 0; exc_i = 0; e_ld_addr_mis_i = 0; e_st_addr_mis_i = 0;
  endtask

  initial begin
    int kind, resp, nwait, r;
    logic [4:0] rd;
    rst_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall",  stall_o, 0);
    chk("reset_rf_we",  rf_we_o, 0);
    chk("reset_waddr",  rf_waddr_o, 0);
    chk("reset_wdata",  rf_wdata_o, 0);
    chk("reset_retire", retire_o, 0);
    chk("reset_exc",    exc_valid_o, 0);
    chk("reset_cause",  exc_cause_o, 0);
    chk("reset_tval",   exc_tval_o, 0);
    chk("reset_pc",     exc_pc_o, 0);
    step();
    rst_i = 0;

    do_op(K_ALU,   R_ACK,   0, 1, 5'd5,  32'h1234,     32'h0,        32'h100, 0);
    do_op(K_LD,    R_ACK,   3, 1, 5'd10, 32'hDEADBEEF, 32'h2000,     32'h104, 0);
    do_op(K_ST,    R_BOTH,  1, 1, 5'd3,  32'h0,        32'h80000004, 32'h108, 0);
    do_op(K_LDMIS, R_ACK,   0, 1, 5'd7,  32'h0,        32'h1001,     32'h200, 0);
    do_op(K_ALU,   R_ACK,   0, 1, 5'd9,  32'h55,       32'h0,        32'h204, 0);
    do_op(K_LD,    R_TMO,   0, 1, 5'd11, 32'h0,        32'h3000,     32'h208, 0);
    do_op(K_LD,    R_ACK,   2, 1, 5'd0,  32'hCAFEF00D, 32'h3004,     32'h20C, 0);
    do_op(K_ALU,   R_ACK,   0, 1, 5'd0,  32'h77,       32'h0,        32'h210, 0);
    do_op(K_LD,    R_FLUSH, 2, 1, 5'd12, 32'h1111,     32'h3008,     32'h214, 0);
    do_op(K_ST,    R_RST,   1, 1, 5'd0,  32'h0,        32'h300C,     32'h218, 0);
    do_op(K_LD,    R_ACK,   0, 1, 5'd13, 32'hA5A5A5A5, 32'h3010,     32'h21C, 0);
    do_op(K_ST,    R_ERR,   0, 0, 5'd1,  32'h0,        32'h3014,     32'h220, 0);
    do_op(K_LD,    R_ACK,   TMO, 1, 5'd14, 32'h0BADF00D, 32'h3018,   32'h224, 0);
    do_op(K_EXC,   R_ACK,   0, 1, 5'd15, 32'h0,        32'h301C,     32'h228, 4'd2);
    do_op(K_STMIS, R_ACK,   0, 0, 5'd2,  32'h0,        32'h3022,     32'h22C, 0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 3) ? K_ALU : (kind < 5) ? K_LD : (kind == 5) ? K_ST :
             (kind == 6) ? K_EXC : (kind == 7) ? K_LDMIS : (kind == 8) ? K_STMIS : K_LD;
      r = $urandom_range(0, 9);
      resp = (r < 5) ? R_ACK : (r == 5) ? R_ERR : (r == 6) ? R_BOTH :
             (r == 7) ? R_TMO : (r == 8) ? R_FLUSH : R_RST;
      nwait = (resp == R_FLUSH || resp == R_RST) ? $urandom_range(1, 3) : $urandom_range(0, TMO);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(kind, resp, nwait, 1'($urandom), rd, $urandom, $urandom, $urandom, 4'($urandom));
    end

    repeat (3) step();
    chk("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
